// File: rtl/dmem_arbiter.sv
// Round-robin two-master arbiter with per-master lock in front of a single DMEM port.
// Optional forced handover of a stuck lock when ARB_TIMEOUT_EN is defined.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_m0_req,
  input  logic                i_m1_req,
  input  logic                i_m0_we,
  input  logic                i_m1_we,
  input  logic                i_m0_lock,
  input  logic                i_m1_lock,
  input  logic [ADDR_W-1:0]   i_m0_addr,
  input  logic [ADDR_W-1:0]   i_m1_addr,
  input  logic [DATA_W-1:0]   i_m0_wdata,
  input  logic [DATA_W-1:0]   i_m1_wdata,
  input  logic [DATA_W/8-1:0] i_m0_sel,
  input  logic [DATA_W/8-1:0] i_m1_sel,
  output logic                o_m0_gnt,
  output logic                o_m1_gnt,
  output logic [DATA_W-1:0]   o_m0_rdata,
  output logic [DATA_W-1:0]   o_m1_rdata,
  output logic                o_m0_rvalid,
  output logic                o_m1_rvalid,
  output logic                o_s_we,
  output logic [ADDR_W-1:0]   o_s_addr,
  output logic [DATA_W-1:0]   o_s_wdata,
  output logic [DATA_W/8-1:0] o_s_sel,
  input  logic [DATA_W-1:0]   i_s_rdata,
  output logic [1:0]          o_owner,
  output logic                o_timeout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_OWN0 = 2'd1;
  localparam logic [1:0] S_OWN1 = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_next;
  logic       r_last;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_force;

  // Reset kills the grant in the same cycle so an in-flight write never lands.
  assign w_gnt0 = (r_state == S_OWN0) & i_m0_req & ~reset;
  assign w_gnt1 = (r_state == S_OWN1) & i_m1_req & ~reset;

  assign o_m0_gnt = w_gnt0;
  assign o_m1_gnt = w_gnt1;
  assign o_owner  = {r_state == S_OWN1, r_state == S_OWN0};

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;
  logic             w_lock_gnt;

  assign w_lock_gnt = (w_gnt0 & i_m0_lock) | (w_gnt1 & i_m1_lock);
  // Current access is the TIMEOUT-th consecutive locked grant: break the lock after it.
  assign w_force    = w_lock_gnt & (r_cnt == CNT_W'(TIMEOUT - 1)) &
                      ((w_gnt0 & i_m1_req) | (w_gnt1 & i_m0_req));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_force) r_timeout <= 1'b1;
      if (!w_lock_gnt || w_force) r_cnt <= '0;
      else if (r_cnt != CNT_W'(TIMEOUT)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign w_force   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_m0_req & i_m1_req) w_next = r_last ? S_OWN0 : S_OWN1;
        else if (i_m0_req)       w_next = S_OWN0;
        else if (i_m1_req)       w_next = S_OWN1;
      end
      S_OWN0: begin
        if (i_m0_req & i_m0_lock & ~w_force) w_next = S_OWN0;
        else if (i_m1_req)                   w_next = S_OWN1;
        else if (i_m0_req)                   w_next = S_OWN0;
        else                                 w_next = S_IDLE;
      end
      S_OWN1: begin
        if (i_m1_req & i_m1_lock & ~w_force) w_next = S_OWN1;
        else if (i_m0_req)                   w_next = S_OWN0;
        else if (i_m1_req)                   w_next = S_OWN1;
        else                                 w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_s_we    = 1'b0;
    o_s_addr  = '0;
    o_s_wdata = '0;
    o_s_sel   = '0;
    if (w_gnt0) begin
      o_s_we    = i_m0_we;
      o_s_addr  = i_m0_addr;
      o_s_wdata = i_m0_wdata;
      o_s_sel   = i_m0_sel;
    end else if (w_gnt1) begin
      o_s_we    = i_m1_we;
      o_s_addr  = i_m1_addr;
      o_s_wdata = i_m1_wdata;
      o_s_sel   = i_m1_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      o_m0_rvalid <= 1'b0;
      o_m1_rvalid <= 1'b0;
      o_m0_rdata  <= '0;
      o_m1_rdata  <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt0) r_last <= 1'b0;
      if (w_gnt1) r_last <= 1'b1;
      o_m0_rvalid <= w_gnt0 & ~i_m0_we;
      o_m1_rvalid <= w_gnt1 & ~i_m1_we;
      if (w_gnt0 & ~i_m0_we) o_m0_rdata <= i_s_rdata;
      if (w_gnt1 & ~i_m1_we) o_m1_rdata <= i_s_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small DMEM model; timeout checks follow ARB_TIMEOUT_EN.
module tb_dmem_arbiter;
  logic        clk;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_we;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_sel;
  logic [1:0]  owner;
  logic        timeout;
  logic        mem_load;
  logic [31:0] mem [0:15];
  int          total;
  int          passes;
  int          fails;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(3)) dut (
    .clk(clk), .reset(reset),
    .i_m0_req(m0_req), .i_m1_req(m1_req),
    .i_m0_we(m0_we), .i_m1_we(m1_we),
    .i_m0_lock(m0_lock), .i_m1_lock(m1_lock),
    .i_m0_addr(m0_addr), .i_m1_addr(m1_addr),
    .i_m0_wdata(m0_wdata), .i_m1_wdata(m1_wdata),
    .i_m0_sel(m0_sel), .i_m1_sel(m1_sel),
    .o_m0_gnt(m0_gnt), .o_m1_gnt(m1_gnt),
    .o_m0_rdata(m0_rdata), .o_m1_rdata(m1_rdata),
    .o_m0_rvalid(m0_rvalid), .o_m1_rvalid(m1_rvalid),
    .o_s_we(s_we), .o_s_addr(s_addr), .o_s_wdata(s_wdata), .o_s_sel(s_sel),
    .i_s_rdata(s_rdata), .o_owner(owner), .o_timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign s_rdata = mem[s_addr[5:2]];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4] <= 32'hDEADBEEF;
      mem[8] <= 32'h8888_0008;
      mem[9] <= 32'h9999_0009;
    end else if (s_we) begin
      mem[s_addr[5:2]] <= s_wdata;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    total = 0; passes = 0; fails = 0;
    reset = 1'b1; mem_load = 1'b1;
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0; m0_lock = 0; m1_lock = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0; m0_sel = 0; m1_sel = 0;
    tick(); tick();
    mem_load = 1'b0; reset = 1'b0;
    #1;
    chk1("rst_gnt0", m0_gnt, 1'b0);
    chk1("rst_gnt1", m1_gnt, 1'b0);
    chk1("rst_rvalid0", m0_rvalid, 1'b0);
    chk1("rst_rvalid1", m1_rvalid, 1'b0);
    chk32("rst_rdata0", m0_rdata, 32'h0);
    chk32("rst_rdata1", m1_rdata, 32'h0);
    chk32("rst_owner", 32'(owner), 32'h0);
    chk1("rst_timeout", timeout, 1'b0);
    chk1("rst_s_we", s_we, 1'b0);
    chk32("rst_s_addr", s_addr, 32'h0);

    // Single m0 read of 0x10
    m0_req = 1; m0_addr = 32'h10; m0_sel = 4'hF;
    #1;
    chk1("t1_c0_gnt0", m0_gnt, 1'b0);
    tick();
    chk1("t1_c1_gnt0", m0_gnt, 1'b1);
    chk1("t1_c1_gnt1", m1_gnt, 1'b0);
    chk32("t1_c1_s_addr", s_addr, 32'h10);
    chk32("t1_c1_s_sel", 32'(s_sel), 32'hF);
    chk1("t1_c1_s_we", s_we, 1'b0);
    chk32("t1_c1_owner", 32'(owner), 32'h1);
    tick();
    m0_req = 0;
    #1;
    chk1("t1_c2_rvalid0", m0_rvalid, 1'b1);
    chk32("t1_c2_rdata0", m0_rdata, 32'hDEADBEEF);
    chk1("t1_c2_rvalid1", m1_rvalid, 1'b0);
    chk1("t1_c2_gnt1", m1_gnt, 1'b0);
    tick();
    chk1("t1_c3_rvalid0", m0_rvalid, 1'b0);
    chk32("t1_c3_rdata0_hold", m0_rdata, 32'hDEADBEEF);
    chk32("t1_c3_owner", 32'(owner), 32'h0);

    // Both masters read continuously: alternating grants starting with m0
    do_reset();
    m0_req = 1; m0_addr = 32'h20; m0_sel = 4'hF;
    m1_req = 1; m1_addr = 32'h24; m1_sel = 4'hF;
    #1;
    chk1("t2_arb_gnt0", m0_gnt, 1'b0);
    chk1("t2_arb_gnt1", m1_gnt, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk1("t2_gnt0", m0_gnt, (k % 2) == 0);
      chk1("t2_gnt1", m1_gnt, (k % 2) == 1);
      chk32("t2_s_addr", s_addr, ((k % 2) == 0) ? 32'h20 : 32'h24);
      if (k > 0) begin
        chk1("t2_rvalid0", m0_rvalid, (k % 2) == 1);
        chk1("t2_rvalid1", m1_rvalid, (k % 2) == 0);
      end
    end
    tick();
    m0_req = 0; m1_req = 0;
    #1;
    chk1("t2_last_rvalid1", m1_rvalid, 1'b1);
    chk32("t2_rdata1", m1_rdata, 32'h9999_0009);
    chk32("t2_rdata0", m0_rdata, 32'h8888_0008);
    tick(); tick();
    chk32("t2_idle_owner", 32'(owner), 32'h0);

    // Locked m1 write burst with m0 waiting
    do_reset();
    m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 32'h30; m1_wdata = 32'h3100_0000; m1_sel = 4'hF;
    #1;
    chk1("t3_arb_gnt1", m1_gnt, 1'b0);
    tick();
    m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    #1;
    chk1("t3_w0_gnt1", m1_gnt, 1'b1);
    chk1("t3_w0_s_we", s_we, 1'b1);
    chk1("t3_w0_gnt0", m0_gnt, 1'b0);
    for (int k = 1; k < 4; k++) begin
      tick();
      m1_wdata = 32'h3100_0000 + 32'(k);
      if (k == 3) m1_lock = 0;
      #1;
      chk1("t3_w_gnt1", m1_gnt, 1'b1);
      chk1("t3_w_s_we", s_we, 1'b1);
      chk32("t3_w_s_wdata", s_wdata, 32'h3100_0000 + 32'(k));
      chk1("t3_w_gnt0", m0_gnt, 1'b0);
    end
    tick();
    m1_req = 0; m1_we = 0;
    #1;
    chk1("t3_m0_gnt0", m0_gnt, 1'b1);
    chk1("t3_m0_gnt1", m1_gnt, 1'b0);
    chk1("t3_m0_s_we", s_we, 1'b0);
    chk32("t3_m0_s_addr", s_addr, 32'h20);
    chk32("t3_mem_written", mem[12], 32'h3100_0003);
    tick();
    m0_req = 0;
    #1;
    chk1("t3_rvalid0", m0_rvalid, 1'b1);
    chk32("t3_rdata0", m0_rdata, 32'h8888_0008);
    tick(); tick();

    // Reset during an m0 write grant
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'h38; m0_wdata = 32'hBAD0BAD0;
    tick();
    chk1("t4_gnt0", m0_gnt, 1'b1);
    chk1("t4_s_we", s_we, 1'b1);
    reset = 1;
    #1;
    chk1("t4_rst_gnt0", m0_gnt, 1'b0);
    chk1("t4_rst_s_we", s_we, 1'b0);
    tick();
    reset = 0; m0_req = 0; m0_we = 0;
    #1;
    chk32("t4_mem_unchanged", mem[14], 32'h0);
    chk1("t4_after_gnt0", m0_gnt, 1'b0);
    chk1("t4_after_s_we", s_we, 1'b0);
    chk32("t4_after_s_addr", s_addr, 32'h0);
    chk32("t4_after_owner", 32'(owner), 32'h0);
    chk1("t4_after_rvalid0", m0_rvalid, 1'b0);
    chk32("t4_after_rdata0", m0_rdata, 32'h0);
    chk1("t4_after_timeout", timeout, 1'b0);

    // m0 locked forever while m1 requests
    do_reset();
    m0_req = 1; m0_lock = 1; m0_addr = 32'h20;
    m1_req = 1; m1_addr = 32'h24;
    #1;
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 3; k++) begin
      tick();
      chk1("t5_lock_gnt0", m0_gnt, 1'b1);
      chk1("t5_lock_gnt1", m1_gnt, 1'b0);
      chk1("t5_lock_timeout", timeout, 1'b0);
    end
    tick();
    chk1("t5_force_gnt1", m1_gnt, 1'b1);
    chk1("t5_force_gnt0", m0_gnt, 1'b0);
    chk1("t5_force_timeout", timeout, 1'b1);
    tick();
    chk1("t5_back_gnt0", m0_gnt, 1'b1);
    chk1("t5_sticky_timeout", timeout, 1'b1);
    tick();
    chk1("t5_sticky2_timeout", timeout, 1'b1);
`else
    for (int k = 0; k < 100; k++) begin
      tick();
      chk1("t6_lock_gnt0", m0_gnt, 1'b1);
      chk1("t6_lock_gnt1", m1_gnt, 1'b0);
      chk1("t6_timeout", timeout, 1'b0);
    end
`endif
    m0_req = 0; m0_lock = 0; m1_req = 0;
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
